// File: rtl/if_id_queue.sv
// ============================================================================
// Module      : if_id_queue
// Description : IF/ID decoupling queue of DEPTH pre-decoded {PC, INST} entries
//               with valid/ready handshakes on both sides.
//               Optional macro IF_ID_QUEUE_BYPASS_EN: empty-queue fall-through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_queue #(
    parameter int          DEPTH  = 4,
    parameter int          PC_W   = 32,
    parameter logic [4:0]  RA_REG = 5'd1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [31:0]                in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [31:0]                out_inst,
    output logic [11:0]                out_opcode,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int                  c_cnt_w    = $clog2(DEPTH + 1);
    localparam int                  c_ptr_w    = $clog2(DEPTH);
    localparam logic [c_cnt_w-1:0]  c_full     = c_cnt_w'(DEPTH);
    localparam logic [c_ptr_w-1:0]  c_last_ptr = c_ptr_w'(DEPTH - 1);

    logic [PC_W-1:0]    r_pc     [DEPTH];
    logic [31:0]        r_inst   [DEPTH];
    logic [11:0]        r_opcode [DEPTH];
    logic [4:0]         r_rs1    [DEPTH];
    logic [4:0]         r_rs2    [DEPTH];
    logic [4:0]         r_rd     [DEPTH];

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic [5:0]         w_op;
    logic [11:0]        w_dec_opcode;
    logic [4:0]         w_dec_rs1;
    logic [4:0]         w_dec_rs2;
    logic [4:0]         w_dec_rd;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;

    function automatic logic [c_ptr_w-1:0] f_next(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    // Pre-decode happens on the write side so the read path is pure storage.
    assign w_op = in_inst[31:26];

    always_comb begin
        w_dec_opcode = {w_op, (w_op == 6'd0) ? in_inst[5:0] : 6'd0};
        w_dec_rs2    = in_inst[20:16];
        w_dec_rs1    = (w_dec_opcode == 12'h000 || w_dec_opcode == 12'h002)
                       ? in_inst[20:16] : in_inst[25:21];
        if (w_op == 6'd0) begin
            w_dec_rd = in_inst[15:11];
        end else if (w_op == 6'h03) begin
            w_dec_rd = RA_REG;
        end else begin
            w_dec_rd = in_inst[20:16];
        end
    end

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_full);
    assign in_ready = ~w_full;
    assign w_pop    = ~w_empty & out_ready & ~flush;
    assign count    = r_count;

`ifdef IF_ID_QUEUE_BYPASS_EN
    logic w_bypass;
    assign w_bypass = w_empty & in_valid & ~flush;
    // A bypassed instruction consumed in the same cycle is never stored.
    assign w_push   = in_valid & ~w_full & ~flush & ~(w_bypass & out_ready);
`else
    assign w_push   = in_valid & ~w_full & ~flush;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Popped slots are zeroed so an empty queue presents an all-zero bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]     <= '0;
                r_inst[i]   <= '0;
                r_opcode[i] <= '0;
                r_rs1[i]    <= '0;
                r_rs2[i]    <= '0;
                r_rd[i]     <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]     <= '0;
                r_inst[i]   <= '0;
                r_opcode[i] <= '0;
                r_rs1[i]    <= '0;
                r_rs2[i]    <= '0;
                r_rd[i]     <= '0;
            end
        end else begin
            if (w_pop) begin
                r_pc[r_rd_ptr]     <= '0;
                r_inst[r_rd_ptr]   <= '0;
                r_opcode[r_rd_ptr] <= '0;
                r_rs1[r_rd_ptr]    <= '0;
                r_rs2[r_rd_ptr]    <= '0;
                r_rd[r_rd_ptr]     <= '0;
            end
            if (w_push) begin
                r_pc[r_wr_ptr]     <= in_pc;
                r_inst[r_wr_ptr]   <= in_inst;
                r_opcode[r_wr_ptr] <= w_dec_opcode;
                r_rs1[r_wr_ptr]    <= w_dec_rs1;
                r_rs2[r_wr_ptr]    <= w_dec_rs2;
                r_rd[r_wr_ptr]     <= w_dec_rd;
            end
        end
    end

`ifdef IF_ID_QUEUE_BYPASS_EN
    always_comb begin
        out_valid  = ~w_empty | w_bypass;
        out_pc     = r_pc[r_rd_ptr];
        out_inst   = r_inst[r_rd_ptr];
        out_opcode = r_opcode[r_rd_ptr];
        out_rs1    = r_rs1[r_rd_ptr];
        out_rs2    = r_rs2[r_rd_ptr];
        out_rd     = r_rd[r_rd_ptr];
        if (w_bypass) begin
            out_pc     = in_pc;
            out_inst   = in_inst;
            out_opcode = w_dec_opcode;
            out_rs1    = w_dec_rs1;
            out_rs2    = w_dec_rs2;
            out_rd     = w_dec_rd;
        end
    end
`else
    assign out_valid  = ~w_empty;
    assign out_pc     = r_pc[r_rd_ptr];
    assign out_inst   = r_inst[r_rd_ptr];
    assign out_opcode = r_opcode[r_rd_ptr];
    assign out_rs1    = r_rs1[r_rd_ptr];
    assign out_rs2    = r_rs2[r_rd_ptr];
    assign out_rd     = r_rd[r_rd_ptr];
`endif

endmodule

`default_nettype wire

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised IF/ID decoupling queue between instruction fetch and decode.
- Holds up to DEPTH fetched {PC, INST} pairs.
- Pre-decodes each instruction at write time into opcode and register indices.
- Uses valid/ready handshakes on both sides, so IF and ID stall independently. Replaces the single-entry IF/ID register.

Parameters:
DEPTH, 4, number of entries; any integer >= 2
PC_W, 32, width of PC field
RA_REG, 5'd1, destination register index written for jal

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; asynchronous, active-high
flush  input  1  synchronous flush of all entries (branch/jump redirect)
in_valid  input  1  IF presents an instruction
in_ready  output  1  queue can accept; equals !full
in_pc  input  PC_W  PC of fetched instruction
in_inst  input  32  fetched instruction word
out_valid  output  1  head entry valid
out_ready  input  1  ID consumes head this cycle
out_pc  output  PC_W  head PC
out_inst  output  32  head instruction
out_opcode  output  12  {inst[31:26], funct or 0}
out_rs1  output  5  source 1 index
out_rs2  output  5  source 2 index
out_rd  output  5  destination index
count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, all storage cleared, out_valid=0, in_ready=1, all out_* fields=0.
- push = in_valid & in_ready & !flush.
- pop = out_valid & out_ready & !flush.
- Pre-decode is applied to in_inst on push, and the result is stored with the entry:
  - opcode = {inst[31:26], (inst[31:26]==0) ? inst[5:0] : 6'd0}.
  - rs2 = inst[20:16].
  - rs1 = inst[20:16] if opcode == 12'h000 (sll) or 12'h002 (srl); else inst[25:21].
  - rd = inst[15:11] if inst[31:26]==0; RA_REG if inst[31:26]==6'h03 (jal); else inst[20:16].
- Output timing: out_* driven directly from the storage entry at rd_ptr, with no combinational decode on the output path. out_valid = (count != 0).
- When empty, all out_* fields read 0 (bubble). The entry slot is zeroed on pop.
- Latency: push in cycle N appears on out_valid in cycle N+1 (without the bypass feature).
- Pointers increment on push/pop and wrap from DEPTH-1 to 0. DEPTH need not be a power of two.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
- Full (count==DEPTH): in_ready=0 and in_valid is ignored. A pop in the same cycle does not enable a push; in_ready rises the following cycle.
- Empty: out_ready is ignored and no underflow occurs.
- Simultaneous push+pop at 0<count<DEPTH: both occur, and count is unchanged.
- flush=1: at the next edge, count=0, pointers=0, and all entries are zeroed. Flush overrides any push/pop in that cycle; the concurrent in_* is dropped.
- Reset asserted mid-operation: the queue clears immediately regardless of clk.

Optional Feature:
Macro IF_ID_QUEUE_BYPASS_EN.
- Defined:
  - When count==0, in_valid=1 and flush=0, out_valid=1 in the same cycle, with out_* taken from in_pc/in_inst through the pre-decode logic (combinational).
  - If out_ready=1 as well, the instruction is consumed and not stored (count stays 0). Otherwise it is stored normally.
- Undefined: no combinational path from in_* to out_*; minimum latency is 1 cycle.

Test Plan:
- Reset/empty: assert rst mid-cycle with count=2 -> count=0, out_valid=0, all out_*=0, in_ready=1 immediately.
- Decode: push inst 32'h0C000040 (jal) at pc 32'h100 -> next cycle out_opcode=12'h0C0, out_rd=1, out_pc=32'h100. Push 32'h00041080 (sll $2,$4,2) -> out_opcode=12'h000, out_rs1=4, out_rs2=4, out_rd=2.
- Fill/full with DEPTH=4, out_ready=0: push 5 instructions -> count=4, in_ready=0 after the 4th, and the 5th is not stored. Then drain -> PCs emerge in push order.
- Wrap-around with DEPTH=3: sustained push+pop for 10 cycles -> count constant at 1, output order matches input order across pointer wrap.
- Flush: count=3, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, the in_* of the flush cycle is never output.
- Bypass (macro defined): empty queue, in_valid=1, out_ready=1 -> out_valid=1 in the same cycle with decoded fields, count remains 0. Macro undefined -> out_valid=0 in the same cycle and 1 the next.
